// File: rtl/pixel_plane_writer.sv
// Pixel plane writer: single-pixel and rectangle fills into a y*W+x plane.
// One registered write per cycle, addresses stepped incrementally.
module pixel_plane_writer #(
    parameter int PLANE_W = 320,
    parameter int PLANE_H = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    input  logic [7:0]  color,
    input  logic        abort,
    output logic [16:0] vram_addr,
    output logic [7:0]  vram_d,
    output logic        vram_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [16:0] ROW   = 17'(PLANE_W);
    localparam logic [9:0]  W_LIM = 10'(PLANE_W);
    localparam logic [8:0]  H_LIM = 9'(PLANE_H);
    localparam logic [8:0]  X_MAX = 9'(PLANE_W - 1);
    localparam logic [7:0]  Y_MAX = 8'(PLANE_H - 1);

    state_t      state, nxt;
    logic        live_q;
    logic        err_q;
    logic [8:0]  cur_x, start_x, end_x;
    logic [7:0]  cur_y, end_y;
    logic [16:0] line_base;

    logic        accept;
    logic        last;
    logic        bad;
    logic [8:0]  raw_x1, clamp_x1;
    logic [7:0]  raw_y1, clamp_y1;
    logic [16:0] base0;

    // Command decode: single pixel collapses the rectangle, far corner clamps
    always_comb begin
        raw_x1   = cmd_op ? x1 : x0;
        raw_y1   = cmd_op ? y1 : y0;
        clamp_x1 = ({1'b0, raw_x1} > 10'(X_MAX)) ? X_MAX : raw_x1;
        clamp_y1 = ({1'b0, raw_y1} > 9'(Y_MAX)) ? Y_MAX : raw_y1;
        bad      = ({1'b0, x0} >= W_LIM) || ({1'b0, y0} >= H_LIM) ||
                   (raw_x1 < x0) || (raw_y1 < y0);
        base0    = 17'(y0) * ROW;
        last     = (cur_x == end_x) && (cur_y == end_y);
    end

    assign cmd_ready = (state == IDLE) && live_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;

    // Next-state logic
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    nxt    = bad ? DONE : FILL;
                end
            end
            FILL: begin
                if (abort || last) begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register; ready only once the first edge after reset has passed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            live_q <= 1'b0;
        end else begin
            state  <= nxt;
            live_q <= 1'b1;
        end
    end

    // Raster walker and registered write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_d    <= '0;
            err_q     <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            start_x   <= '0;
            end_x     <= '0;
            end_y     <= '0;
            line_base <= '0;
        end else if (accept) begin
            cur_x     <= x0;
            cur_y     <= y0;
            start_x   <= x0;
            end_x     <= clamp_x1;
            end_y     <= clamp_y1;
            line_base <= base0;
            vram_addr <= bad ? '0 : base0 + 17'(x0);
            vram_d    <= color;
            vram_we   <= !bad;
            err_q     <= bad;
        end else if (state == FILL && !abort && !last) begin
            vram_we <= 1'b1;
            if (cur_x == end_x) begin
                cur_x     <= start_x;
                cur_y     <= cur_y + 8'd1;
                line_base <= line_base + ROW;
                vram_addr <= line_base + ROW + 17'(start_x);
            end else begin
                cur_x     <= cur_x + 9'd1;
                vram_addr <= vram_addr + 17'd1;
            end
        end else begin
            vram_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_plane_writer.sv
// Directed bench for pixel_plane_writer: single pixel, rectangles,
// clamping, rejects, abort and mid-fill reset.
module tb_pixel_plane_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [8:0]  x0, x1;
    logic [7:0]  y0, y1, color;
    logic        abort;
    logic [16:0] vram_addr;
    logic [7:0]  vram_d;
    logic        vram_we, busy, done, err;

    int nvec = 0;
    int nerr = 0;
    logic [16:0] wa[$];
    logic [7:0]  wd[$];

    pixel_plane_writer dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .abort(abort), .vram_addr(vram_addr), .vram_d(vram_d),
        .vram_we(vram_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log every write cycle mid-cycle
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            wa.push_back(vram_addr);
            wd.push_back(vram_d);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [8:0] a, input logic [7:0] b,
                        input logic [8:0] c, input logic [7:0] d,
                        input logic [7:0] col);
        cmd_valid = 1'b1;
        cmd_op = op; x0 = a; y0 = b; x1 = c; y1 = d; color = col;
        tick();
        cmd_valid = 1'b0;
        cmd_op = ~op; x0 = 9'd7; y0 = 8'd9; x1 = 9'd3; y1 = 8'd1;
        color = 8'h55;
    endtask

    // Count edges after acceptance until done is seen, bounded
    task automatic wait_done(input string tag, input int lim, output int k);
        k = 0;
        while (done !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_addr(input string tag, input int i, input logic [16:0] e);
        chk(tag, (i < wa.size()) ? 32'(wa[i]) : 32'hdead, 32'(e));
    endtask

    int k;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; abort = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        #2;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", vram_we, 0);
        chk("rst_done", {done, err}, 0);
        chk("rst_addr", vram_addr, 0);
        tick();
        chk("rst_ready_clk", cmd_ready, 0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // Single pixel; x1/y1 must be ignored, abort ignored in idle
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, done, cmd_ready}, 3'b001);
        wa.delete(); wd.delete();
        send(1'b0, 9'd5, 8'd2, 9'd100, 8'd100, 8'hE0);
        chk("px_we", vram_we, 1);
        chk("px_addr", vram_addr, 645);
        chk("px_d", vram_d, 8'hE0);
        chk("px_busy_rdy", {busy, cmd_ready}, 2'b10);
        tick();
        chk("px_done", {vram_we, done, err}, 3'b010);
        tick();
        chk("px_idle", {done, busy, cmd_ready}, 3'b001);
        chk("px_nwr", wa.size(), 1);

        // 3x2 rectangle
        wa.delete(); wd.delete();
        send(1'b1, 9'd0, 8'd0, 9'd2, 8'd1, 8'h1C);
        wait_done("rect", 20, k);
        chk("rect_lat", k, 6);
        chk("rect_err", err, 0);
        chk("rect_nwr", wa.size(), 6);
        chk_addr("rect_a0", 0, 0);
        chk_addr("rect_a1", 1, 1);
        chk_addr("rect_a2", 2, 2);
        chk_addr("rect_a3", 3, 320);
        chk_addr("rect_a4", 4, 321);
        chk_addr("rect_a5", 5, 322);
        chk("rect_d", (wd.size() > 5) ? 32'(wd[5]) : 32'hdead, 8'h1C);
        tick();

        // Clamped corner
        wa.delete(); wd.delete();
        send(1'b1, 9'd318, 8'd238, 9'd400, 8'd250, 8'h03);
        wait_done("clamp", 20, k);
        chk("clamp_lat", k, 4);
        chk("clamp_nwr", wa.size(), 4);
        chk_addr("clamp_a0", 0, 76478);
        chk_addr("clamp_a1", 1, 76479);
        chk_addr("clamp_a2", 2, 76798);
        chk_addr("clamp_a3", 3, 76799);
        tick();

        // Rejects: x0 out of range, x1<x0, y1<y0
        wa.delete(); wd.delete();
        send(1'b0, 9'd320, 8'd0, 9'd0, 8'd0, 8'hFF);
        chk("rej_x0", {vram_we, done, err}, 3'b011);
        tick();
        chk("rej_x0_end", {done, err, cmd_ready}, 3'b001);
        send(1'b1, 9'd10, 8'd0, 9'd5, 8'd0, 8'hFF);
        chk("rej_x1", {vram_we, done, err}, 3'b011);
        tick();
        send(1'b1, 9'd0, 8'd10, 9'd5, 8'd4, 8'hFF);
        chk("rej_y1", {vram_we, done, err}, 3'b011);
        tick();
        chk("rej_nwr", wa.size(), 0);

        // Full plane with abort at the edge ending the third write
        wa.delete(); wd.delete();
        send(1'b1, 9'd0, 8'd0, 9'd319, 8'd239, 8'hAA);
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("abort_done", {vram_we, done, err}, 3'b010);
        tick();
        chk("abort_in_done", {busy, cmd_ready}, 2'b01);
        abort = 1'b0;
        chk("abort_nwr", wa.size(), 3);
        chk_addr("abort_a2", 2, 2);

        // Reset mid-fill
        send(1'b1, 9'd0, 8'd0, 9'd319, 8'd239, 8'h11);
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_we_busy", {vram_we, busy}, 0);
        tick();
        reset_n = 1'b1;
        wa.delete(); wd.delete();
        tick();
        chk("mrst_ready", cmd_ready, 1);
        repeat (10) tick();
        chk("mrst_nwr", wa.size(), 0);
        send(1'b1, 9'd1, 8'd1, 9'd2, 8'd1, 8'h42);
        wait_done("post", 20, k);
        chk("post_lat", k, 2);
        chk("post_nwr", wa.size(), 2);
        chk_addr("post_a1", 1, 322);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_plane_writer.md
PIXEL_PLANE_WRITER -- requirements
Module: pixel_plane_writer

Interface
REQ-001 SHALL have parameter PLANE_W, default 320, pixel plane width in pixels.
REQ-002 SHALL have parameter PLANE_H, default 240, pixel plane height in lines.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_op  input  1  command type: 0 = single pixel at (x0,y0), 1 = inclusive rectangle fill (x0,y0)-(x1,y1).
REQ-008 SHALL have ports x0, x1  input  9 each  column coordinates.
REQ-009 SHALL have ports y0, y1  input  8 each  line coordinates.
REQ-010 SHALL have port color  input  8  pixel value, RRRGGGBB.
REQ-011 SHALL have port abort  input  1  terminate the fill in progress.
REQ-012 SHALL have port vram_addr  output  17  pixel plane write address, y*PLANE_W+x.
REQ-013 SHALL have port vram_d  output  8  write data.
REQ-014 SHALL have port vram_we  output  1  write strobe, one pixel per cycle.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at command end.
REQ-017 SHALL have port err  output  1  one-cycle pulse coincident with done on a rejected command.

Function
REQ-018 SHALL implement states IDLE, FILL, DONE.
REQ-019 SHALL drive cmd_ready high only in IDLE; a command is accepted at an edge where cmd_valid and cmd_ready are both high.
REQ-020 SHALL capture cmd_op, x0, y0, x1, y1 and color at acceptance and ignore later changes on those inputs.
REQ-021 SHALL, for cmd_op=0, treat x1=x0 and y1=y0.
REQ-022 SHALL clamp x1 to PLANE_W-1 and y1 to PLANE_H-1 before filling.
REQ-023 SHALL reject a command if x0>=PLANE_W, y0>=PLANE_H, x1<x0 or y1<y0: go to DONE with no write, so done and err pulse in the cycle after acceptance.
REQ-024 SHALL, for a valid command, go to FILL and issue the first write in the cycle after acceptance.
REQ-025 SHALL write pixels in raster order: x from x0 to x1, then next line, y from y0 to y1.
REQ-026 SHALL keep vram_we high for one cycle per pixel with no gaps, so an NxM rectangle produces N*M consecutive write cycles.
REQ-027 SHALL compute addresses incrementally: +1 along a line, line base +PLANE_W per line, with no multiplier in the per-pixel path.
REQ-028 SHALL register vram_addr, vram_d and vram_we.
REQ-029 SHALL enter DONE after the final write and pulse done, err=0, in the cycle after the last vram_we.
REQ-030 SHALL return from DONE to IDLE after one cycle; cmd_ready is high again on the next cycle.
REQ-031 SHALL, when abort is high at an edge in FILL, hold vram_we low from that edge and enter DONE (done pulse, err=0).
REQ-032 SHALL ignore abort in IDLE and in DONE.
REQ-033 SHALL hold vram_we low outside FILL.
REQ-034 SHALL never produce an address at or above PLANE_W*PLANE_H.

Reset
REQ-035 SHALL, while reset_n is low, force state IDLE and drive vram_we=0, vram_addr=0, vram_d=0, busy=0, done=0, err=0 and cmd_ready=0, regardless of clk.
REQ-036 SHALL drive cmd_ready=1 from the first edge after reset_n deasserts.
REQ-037 SHALL, on reset mid-FILL, drop vram_we immediately and discard the command, with no resumption after release.

Verification
REQ-038 SHALL cover: op=0 at (5,2), color 0xE0 accepted at T -> single write at T+1, addr 645, d 0xE0; done at T+2; cmd_ready high at T+3.
REQ-039 SHALL cover: op=1 (0,0)-(2,1), color 0x1C -> six consecutive writes to addrs 0,1,2,320,321,322; done the cycle after the last write.
REQ-040 SHALL cover: op=1 (318,238)-(400,250) -> clamped, exactly four writes to 76478, 76479, 76798, 76799.
REQ-041 SHALL cover: x0=320, or x1<x0 -> no vram_we; done and err both pulse at T+1.
REQ-042 SHALL cover: full-plane fill with abort high at the edge ending the third write -> exactly 3 writes (addrs 0,1,2), then done pulse with err=0.
REQ-043 SHALL cover: reset_n low mid-fill -> vram_we and busy fall asynchronously; after release no further writes and cmd_ready=1; a new command completes normally.
